pwm_carrier_sequencer: RTL and testbench



---
 rtl/pwm_carrier_sequencer_pkg.sv | 28 ++
 rtl/pwm_carrier_sequencer_if.sv | 42 ++++
 rtl/pwm_carrier_sequencer_timeout.sv | 39 +++
 rtl/pwm_carrier_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_pwm_carrier_sequencer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_carrier_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_carrier_sequencer_pkg
// Purpose  : Shared PWM definitions for the carrier start/stop sequencer.
//            Holds the sequencer state type and sizing constants.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pwm_carrier_sequencer_pkg;

   // Default width of the stagger delay counter
   localparam int SEQ_DLY_WIDTH = 16;

   // Largest number of carrier channels the sequencer can drive
   localparam int SEQ_NCARR_MAX = 8;

   // Encoding is visible on the status port, so values are fixed
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_STAGGER  = 3'd1,
      ST_SYNC     = 3'd2,
      ST_RUN      = 3'd3,
      ST_STOPPING = 3'd4,
      ST_FAULT    = 3'd5
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_carrier_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_carrier_sequencer_if
// Purpose  : Control/status bundle between a PWM controller and the carrier
//            sequencer.
// Ports    : master - drives start/stop/fault/fault_clr/stagger_dly/maskevent,
//                     reads enables and status
//            slave  - the sequencer side (mirror of master)
// Revision : 1.0 - initial release
// ============================================================================
interface pwm_carrier_sequencer_if
   import pwm_carrier_sequencer_pkg::*;
#(
   parameter int N_CARR    = 4,
   parameter int DLY_WIDTH = SEQ_DLY_WIDTH
) ();

   logic                 start;
   logic                 stop;
   logic                 fault;
   logic                 fault_clr;
   logic [DLY_WIDTH-1:0] stagger_dly;
   logic [N_CARR-1:0]    maskevent;
   logic [N_CARR-1:0]    carr_onoff;
   logic [N_CARR-1:0]    pwm_onoff;
   logic                 int_onoff;
   logic                 busy;
   logic                 sync_err;
   logic [2:0]           state;

   modport master (
      output start, stop, fault, fault_clr, stagger_dly, maskevent,
      input  carr_onoff, pwm_onoff, int_onoff, busy, sync_err, state
   );

   modport slave (
      input  start, stop, fault, fault_clr, stagger_dly, maskevent,
      output carr_onoff, pwm_onoff, int_onoff, busy, sync_err, state
   );

endinterface
`default_nettype wire

// File: rtl/pwm_carrier_sequencer_timeout.sv
`default_nettype none
// ============================================================================
// Module   : seq_timeout_counter
// Purpose  : Boundary-wait watchdog. Counts enabled cycles and flags expiry
//            on the cycle in which the count would reach SYNC_TIMEOUT.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            i_clr         - hold count at zero
//            i_en          - count this cycle
//            o_expired     - terminal count reached (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module seq_timeout_counter #(
   parameter int SYNC_TIMEOUT = 65535
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int CNT_W = $clog2(SYNC_TIMEOUT + 1);

   logic [CNT_W-1:0] r_count;

   // The SYNC_TIMEOUT-th waiting cycle is the one whose count is
   // SYNC_TIMEOUT-1, so expiry is flagged there and acted on at its edge.
   assign o_expired = i_en && (r_count == CNT_W'(SYNC_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_count <= '0;
      end else if (i_en && !o_expired) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/pwm_carrier_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pwm_carrier_sequencer
// Purpose  : Start/stop sequencer for N_CARR carrier channels. Enables the
//            carriers one by one with a programmable stagger, releases all PWM
//            outputs on a maskevent[0] boundary, stops on a boundary, and shuts
//            down immediately on fault or boundary-wait timeout.
// Ports    : clk, reset    - clock, synchronous active-high reset
//            bus (slave)   - start/stop/fault/fault_clr/stagger_dly/maskevent
//                            in; carr_onoff/pwm_onoff/int_onoff/busy/
//                            sync_err/state out (all registered)
// Revision : 1.0 - initial release
// ============================================================================
module pwm_carrier_sequencer
   import pwm_carrier_sequencer_pkg::*;
#(
   parameter int N_CARR       = 4,
   parameter int DLY_WIDTH    = SEQ_DLY_WIDTH,
   parameter int SYNC_TIMEOUT = 65535
) (
   input  logic                  clk,
   input  logic                  reset,
   pwm_carrier_sequencer_if.slave bus
);

   localparam int IDX_W = $clog2(SEQ_NCARR_MAX + 1);

   seq_state_t           r_state, w_state_nxt;
   logic [N_CARR-1:0]    r_carr, w_carr_nxt;
   logic [N_CARR-1:0]    r_pwm, w_pwm_nxt;
   logic                 r_int, w_int_nxt;
   logic                 r_busy;
   logic                 r_err, w_err_nxt;
   logic [DLY_WIDTH-1:0] r_dly, w_dly_nxt;
   logic [DLY_WIDTH-1:0] r_cnt, w_cnt_nxt;
   logic [IDX_W-1:0]     r_idx, w_idx_nxt;
   logic                 w_clear;
   logic                 w_wait;
   logic                 w_expired;
   logic                 w_me0;
   logic                 w_maskevent_unused;

   // Only the channel-0 boundary matters; other mask events are don't-care
   assign w_me0              = bus.maskevent[0];
   assign w_maskevent_unused = ^bus.maskevent;

   // Watchdog is live only while waiting for a boundary and sits at zero
   // otherwise, so it always starts a wait from zero.
   assign w_wait = (r_state == ST_SYNC) || (r_state == ST_STOPPING);

   seq_timeout_counter #(
      .SYNC_TIMEOUT (SYNC_TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .rst       (reset),
      .i_clr     (!w_wait),
      .i_en      (w_wait),
      .o_expired (w_expired)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_carr_nxt  = r_carr;
      w_pwm_nxt   = r_pwm;
      w_int_nxt   = r_int;
      w_err_nxt   = r_err;
      w_dly_nxt   = r_dly;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_clear     = 1'b0;

      if (bus.fault) begin
         w_state_nxt = ST_FAULT;
         w_clear     = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start && !bus.stop) begin
                  w_dly_nxt   = bus.stagger_dly;
                  w_carr_nxt  = N_CARR'(1);
                  w_idx_nxt   = IDX_W'(1);
                  w_cnt_nxt   = '0;
                  w_state_nxt = (N_CARR == 1) ? ST_SYNC : ST_STAGGER;
               end
            end
            ST_STAGGER: begin
               if (bus.stop) begin
                  w_state_nxt = ST_IDLE;
                  w_clear     = 1'b1;
               end else if (r_cnt == r_dly) begin
                  for (int i = 0; i < N_CARR; i++) begin
                     if (r_idx == IDX_W'(i)) begin
                        w_carr_nxt[i] = 1'b1;
                     end
                  end
                  w_idx_nxt = r_idx + IDX_W'(1);
                  w_cnt_nxt = '0;
                  if (r_idx == IDX_W'(N_CARR - 1)) begin
                     w_state_nxt = ST_SYNC;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + DLY_WIDTH'(1);
               end
            end
            ST_SYNC: begin
               // A boundary on the expiring cycle still counts as in time
               if (bus.stop) begin
                  w_state_nxt = ST_IDLE;
                  w_clear     = 1'b1;
               end else if (w_me0) begin
                  w_pwm_nxt   = '1;
                  w_int_nxt   = 1'b1;
                  w_state_nxt = ST_RUN;
               end else if (w_expired) begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = ST_FAULT;
                  w_clear     = 1'b1;
               end
            end
            ST_RUN: begin
               if (bus.stop) begin
                  w_state_nxt = ST_STOPPING;
               end
            end
            ST_STOPPING: begin
               if (w_me0) begin
                  w_state_nxt = ST_IDLE;
                  w_clear     = 1'b1;
               end else if (w_expired) begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = ST_FAULT;
                  w_clear     = 1'b1;
               end
            end
            ST_FAULT: begin
               if (bus.fault_clr) begin
                  w_err_nxt   = 1'b0;
                  w_state_nxt = ST_IDLE;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_clear     = 1'b1;
            end
         endcase
      end

      if (w_clear) begin
         w_carr_nxt = '0;
         w_pwm_nxt  = '0;
         w_int_nxt  = 1'b0;
         w_idx_nxt  = '0;
         w_cnt_nxt  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_carr  <= '0;
         r_pwm   <= '0;
         r_int   <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
         r_dly   <= '0;
         r_cnt   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_carr  <= w_carr_nxt;
         r_pwm   <= w_pwm_nxt;
         r_int   <= w_int_nxt;
         r_busy  <= (w_state_nxt != ST_IDLE);
         r_err   <= w_err_nxt;
         r_dly   <= w_dly_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   assign bus.carr_onoff = r_carr;
   assign bus.pwm_onoff  = r_pwm;
   assign bus.int_onoff  = r_int;
   assign bus.busy       = r_busy;
   assign bus.sync_err   = r_err;
   assign bus.state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pwm_carrier_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_carrier_sequencer
// Purpose  : Self-checking bench for pwm_carrier_sequencer (N_CARR=4,
//            SYNC_TIMEOUT=16). Directed scenarios followed by random traffic,
//            all compared each cycle against a phase/elapsed-time model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_carrier_sequencer;

   localparam int N  = 4;
   localparam int TO = 16;

   localparam int P_IDLE = 0, P_STAGGER = 1, P_SYNC = 2,
                  P_RUN = 3, P_STOPPING = 4, P_FAULT = 5;

   logic clk = 1'b0;
   logic reset;

   int checks = 0;
   int errors = 0;

   // Reference model: current phase, cycles spent in it, latched delay
   int m_phase = P_IDLE;
   int m_t     = 0;
   int m_dly   = 0;
   bit m_err   = 1'b0;

   pwm_carrier_sequencer_if #(.N_CARR(N), .DLY_WIDTH(16)) bus ();

   pwm_carrier_sequencer #(
      .N_CARR       (N),
      .DLY_WIDTH    (16),
      .SYNC_TIMEOUT (TO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Carriers come on one every (dly+1) cycles starting with channel 0
   function automatic logic [31:0] exp_carr();
      int bits;
      case (m_phase)
         P_STAGGER: begin
            bits = 1 + m_t / (m_dly + 1);
            return 32'((1 << bits) - 1);
         end
         P_SYNC, P_RUN, P_STOPPING: return 32'((1 << N) - 1);
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_step();
      int nxt;
      nxt = m_phase;
      if (reset) begin
         nxt   = P_IDLE;
         m_err = 1'b0;
      end else if (bus.fault) begin
         nxt = P_FAULT;
      end else begin
         case (m_phase)
            P_IDLE:
               if (bus.start && !bus.stop) begin
                  m_dly = int'(bus.stagger_dly);
                  nxt   = (N == 1) ? P_SYNC : P_STAGGER;
               end
            P_STAGGER:
               if (bus.stop) nxt = P_IDLE;
               else if (m_t + 1 == (N - 1) * (m_dly + 1)) nxt = P_SYNC;
            P_SYNC:
               if (bus.stop) nxt = P_IDLE;
               else if (bus.maskevent[0]) nxt = P_RUN;
               else if (m_t + 1 == TO) begin m_err = 1'b1; nxt = P_FAULT; end
            P_RUN:
               if (bus.stop) nxt = P_STOPPING;
            P_STOPPING:
               if (bus.maskevent[0]) nxt = P_IDLE;
               else if (m_t + 1 == TO) begin m_err = 1'b1; nxt = P_FAULT; end
            P_FAULT:
               if (bus.fault_clr) begin m_err = 1'b0; nxt = P_IDLE; end
            default: nxt = P_IDLE;
         endcase
      end
      if (reset || nxt != m_phase) m_t = 0;
      else m_t++;
      m_phase = nxt;
   endtask

   task automatic check_all();
      logic [31:0] on_run;
      on_run = (m_phase == P_RUN || m_phase == P_STOPPING) ? 32'd1 : 32'd0;
      chk("state",      32'(bus.state),      32'(m_phase));
      chk("carr_onoff", 32'(bus.carr_onoff), exp_carr());
      chk("pwm_onoff",  32'(bus.pwm_onoff),  on_run * 32'((1 << N) - 1));
      chk("int_onoff",  32'(bus.int_onoff),  on_run);
      chk("busy",       32'(bus.busy),       32'(m_phase != P_IDLE));
      chk("sync_err",   32'(bus.sync_err),   32'(m_err));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic drive(input bit s, input bit p, input bit f, input bit c, input bit [N-1:0] me);
      bus.start     = s;
      bus.stop      = p;
      bus.fault     = f;
      bus.fault_clr = c;
      bus.maskevent = me;
   endtask

   initial begin
      reset = 1'b1;
      bus.stagger_dly = 16'd0;
      drive(0, 0, 0, 0, '0);
      tick();
      chk("reset_state", 32'(bus.state), 32'd0);
      reset = 1'b0;

      // Plan 1: stagger 2, boundary at cycle 20
      bus.stagger_dly = 16'd2;
      drive(1, 0, 0, 0, '0);
      tick();
      chk("p1_c1_carr", 32'(bus.carr_onoff), 32'h1);
      drive(0, 0, 0, 0, '0);
      ticks(3);
      chk("p1_c4_carr", 32'(bus.carr_onoff), 32'h3);
      ticks(3);
      chk("p1_c7_carr", 32'(bus.carr_onoff), 32'h7);
      ticks(3);
      chk("p1_c10_carr", 32'(bus.carr_onoff), 32'hF);
      chk("p1_c10_state", 32'(bus.state), 32'd2);
      ticks(10);
      drive(0, 0, 0, 0, 4'b0001);
      tick();
      chk("p1_c21_pwm", 32'(bus.pwm_onoff), 32'hF);
      chk("p1_c21_int", 32'(bus.int_onoff), 32'd1);
      chk("p1_c21_state", 32'(bus.state), 32'd3);

      // Plan 2: orderly stop, boundary 5 cycles after stop
      drive(0, 1, 0, 0, 4'b1110);
      tick();
      drive(0, 0, 0, 0, 4'b1110);
      ticks(4);
      chk("p2_hold_pwm", 32'(bus.pwm_onoff), 32'hF);
      drive(0, 0, 0, 0, 4'b0001);
      tick();
      chk("p2_idle_state", 32'(bus.state), 32'd0);
      chk("p2_idle_busy", 32'(bus.busy), 32'd0);
      chk("p2_idle_carr", 32'(bus.carr_onoff), 32'd0);

      // Plan 3: zero stagger, then abort from SYNC
      bus.stagger_dly = 16'd0;
      drive(1, 0, 0, 0, '0);
      tick();
      chk("p3_c1", 32'(bus.carr_onoff), 32'h1);
      drive(0, 0, 0, 0, '0);
      tick();
      chk("p3_c2", 32'(bus.carr_onoff), 32'h3);
      tick();
      chk("p3_c3", 32'(bus.carr_onoff), 32'h7);
      tick();
      chk("p3_c4", 32'(bus.carr_onoff), 32'hF);
      drive(0, 1, 0, 0, '0);
      tick();
      chk("p3_abort_state", 32'(bus.state), 32'd0);
      chk("p3_abort_carr", 32'(bus.carr_onoff), 32'd0);

      // Plan 4: fault during stagger
      bus.stagger_dly = 16'd2;
      drive(1, 0, 0, 0, '0);
      tick();
      drive(0, 0, 0, 0, '0);
      ticks(4);
      drive(0, 0, 1, 0, '0);
      tick();
      chk("p4_fault_state", 32'(bus.state), 32'd5);
      chk("p4_fault_carr", 32'(bus.carr_onoff), 32'd0);
      drive(1, 0, 0, 0, '0);
      tick();
      chk("p4_start_ignored", 32'(bus.state), 32'd5);
      drive(0, 0, 1, 1, '0);
      tick();
      chk("p4_clr_blocked", 32'(bus.state), 32'd5);
      drive(0, 0, 0, 1, '0);
      tick();
      chk("p4_clr_idle", 32'(bus.state), 32'd0);

      // Plan 5: sync timeout, then boundary on the expiring cycle
      bus.stagger_dly = 16'd0;
      drive(1, 0, 0, 0, '0);
      tick();
      drive(0, 0, 0, 0, '0);
      ticks(3 + 15);
      chk("p5_c19_state", 32'(bus.state), 32'd2);
      tick();
      chk("p5_to_state", 32'(bus.state), 32'd5);
      chk("p5_to_err", 32'(bus.sync_err), 32'd1);
      drive(0, 0, 0, 1, '0);
      tick();
      chk("p5_err_cleared", 32'(bus.sync_err), 32'd0);
      drive(1, 0, 0, 0, '0);
      tick();
      drive(0, 0, 0, 0, '0);
      ticks(3 + 15);
      drive(0, 0, 0, 0, 4'b0001);
      tick();
      chk("p5_edge_run", 32'(bus.state), 32'd3);
      chk("p5_edge_err", 32'(bus.sync_err), 32'd0);
      drive(0, 1, 0, 0, '0);
      tick();
      drive(0, 0, 0, 0, '0);
      ticks(16);
      chk("p5_stop_to_state", 32'(bus.state), 32'd5);
      drive(0, 0, 0, 1, '0);
      tick();

      // Plan 6: start+stop together, then reset from RUN
      drive(1, 1, 0, 0, '0);
      tick();
      chk("p6_startstop", 32'(bus.state), 32'd0);
      drive(1, 0, 0, 0, '0);
      tick();
      drive(0, 0, 0, 0, '0);
      ticks(3);
      drive(0, 0, 0, 0, 4'b0001);
      tick();
      chk("p6_run", 32'(bus.state), 32'd3);
      drive(0, 0, 0, 0, '0);
      reset = 1'b1;
      tick();
      chk("p6_rst_pwm", 32'(bus.pwm_onoff), 32'd0);
      chk("p6_rst_carr", 32'(bus.carr_onoff), 32'd0);
      reset = 1'b0;

      // Random traffic against the model
      for (int c = 0; c < 600; c++) begin
         reset           = ($urandom_range(0, 79) == 0);
         bus.stagger_dly = 16'($urandom_range(0, 3));
         drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 11) == 0),
               ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
               {3'($urandom), ($urandom_range(0, 7) == 0)});
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
